// File: rtl/gpu_cmd_decoder.sv
// rtl/gpu_cmd_decoder.sv - command FIFO reader that decodes draw commands for the raster engine
//
// Pops one 83-bit command word at a time from a show-ahead FIFO, decodes it,
// normalises rectangle corners, keeps a current-colour register and presents
// the decoded draw command on a valid/ready handshake.
//
// Ports:
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   fifo_empty          FIFO empty flag
//   fifo_rdata          FIFO head word (show-ahead)
//   fifo_ren            pop strobe, high for exactly one cycle per command
//   cmd_valid/cmd_ready draw command handshake
//   cmd_op              00 LINE, 01 RECT, 10 FILL, 11 CLEAR
//   cmd_color           colour for this command
//   cmd_x0/y0, x1/y1    top-left/bottom-right (or line start/end)
//   busy                decoder not idle
//   err_op              sticky illegal-opcode flag
//
// Optional feature macro GPU_CMD_DEC_STATS_EN adds saturating 16-bit
// counters issued_cnt (handshakes) and dropped_cnt (NOP + illegal words).

module gpu_cmd_decoder #(
    parameter int OP_W     = 3,
    parameter int COLOR_W  = 24,
    parameter int COORD_W  = 14,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 fifo_empty,
    input  logic [OP_W+COLOR_W+4*COORD_W-1:0]    fifo_rdata,
    output logic                                 fifo_ren,
    output logic                                 cmd_valid,
    input  logic                                 cmd_ready,
    output logic [1:0]                           cmd_op,
    output logic [COLOR_W-1:0]                   cmd_color,
    output logic [COORD_W-1:0]                   cmd_x0,
    output logic [COORD_W-1:0]                   cmd_y0,
    output logic [COORD_W-1:0]                   cmd_x1,
    output logic [COORD_W-1:0]                   cmd_y1,
`ifdef GPU_CMD_DEC_STATS_EN
    output logic [15:0]                          issued_cnt,
    output logic [15:0]                          dropped_cnt,
`endif
    output logic                                 busy,
    output logic                                 err_op
);

    localparam int DATA_W = OP_W + COLOR_W + 4 * COORD_W;

    localparam logic [OP_W-1:0] OPC_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OPC_SETC  = OP_W'(1);
    localparam logic [OP_W-1:0] OPC_LINE  = OP_W'(2);
    localparam logic [OP_W-1:0] OPC_RECT  = OP_W'(3);
    localparam logic [OP_W-1:0] OPC_FILL  = OP_W'(4);
    localparam logic [OP_W-1:0] OPC_CLEAR = OP_W'(5);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE} state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    word_q, word_d;
    logic [COLOR_W-1:0]   color_reg_q, color_reg_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [1:0]           cmd_op_q, cmd_op_d;
    logic [COLOR_W-1:0]   cmd_color_q, cmd_color_d;
    logic [COORD_W-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic                 err_op_q, err_op_d;
`ifdef GPU_CMD_DEC_STATS_EN
    logic [15:0]          issued_q, issued_d, dropped_q, dropped_d;
`endif

    // Field views of the captured word
    logic [OP_W-1:0]      w_op;
    logic [COLOR_W-1:0]   w_color, eff_color;
    logic [COORD_W-1:0]   w_x1, w_y1, w_x2, w_y2;

    assign w_op    = word_q[DATA_W-1 -: OP_W];
    assign w_color = word_q[4*COORD_W +: COLOR_W];
    assign w_x1    = word_q[3*COORD_W +: COORD_W];
    assign w_y1    = word_q[2*COORD_W +: COORD_W];
    assign w_x2    = word_q[COORD_W +: COORD_W];
    assign w_y2    = word_q[0 +: COORD_W];
    // A zero colour field means "use the current colour register"
    assign eff_color = (w_color != '0) ? w_color : color_reg_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        color_reg_d = color_reg_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_color_d = cmd_color_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        err_op_d    = err_op_q;
`ifdef GPU_CMD_DEC_STATS_EN
        issued_d    = issued_q;
        dropped_d   = dropped_q;
        if (cmd_valid_q && cmd_ready && issued_q != 16'hFFFF)
            issued_d = issued_q + 16'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                word_d  = fifo_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (w_op)
                    OPC_NOP: begin
`ifdef GPU_CMD_DEC_STATS_EN
                        if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
`endif
                    end
                    OPC_SETC: color_reg_d = w_color;
                    OPC_LINE: begin
                        cmd_op_d    = 2'b00;
                        cmd_color_d = eff_color;
                        x0_d        = w_x1;
                        y0_d        = w_y1;
                        x1_d        = w_x2;
                        y1_d        = w_y2;
                        cmd_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                    OPC_RECT, OPC_FILL: begin
                        cmd_op_d    = (w_op == OPC_RECT) ? 2'b01 : 2'b10;
                        cmd_color_d = eff_color;
                        x0_d        = (w_x1 < w_x2) ? w_x1 : w_x2;
                        x1_d        = (w_x1 < w_x2) ? w_x2 : w_x1;
                        y0_d        = (w_y1 < w_y2) ? w_y1 : w_y2;
                        y1_d        = (w_y1 < w_y2) ? w_y2 : w_y1;
                        cmd_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                    OPC_CLEAR: begin
                        cmd_op_d    = 2'b11;
                        cmd_color_d = w_color;
                        x0_d        = '0;
                        y0_d        = '0;
                        x1_d        = COORD_W'(SCREEN_W - 1);
                        y1_d        = COORD_W'(SCREEN_H - 1);
                        cmd_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                    default: begin
                        err_op_d = 1'b1;
`ifdef GPU_CMD_DEC_STATS_EN
                        if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
`endif
                    end
                endcase
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            color_reg_q <= {COLOR_W{1'b1}};
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_color_q <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            err_op_q    <= 1'b0;
`ifdef GPU_CMD_DEC_STATS_EN
            issued_q    <= '0;
            dropped_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            color_reg_q <= color_reg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_color_q <= cmd_color_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            err_op_q    <= err_op_d;
`ifdef GPU_CMD_DEC_STATS_EN
            issued_q    <= issued_d;
            dropped_q   <= dropped_d;
`endif
        end
    end

    // The pop strobe is a pure decode of the registered state, so it can
    // never assert outside FETCH (in particular never during ISSUE).
    assign fifo_ren  = (state_q == S_FETCH);
    assign busy      = (state_q != S_IDLE);
    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_color = cmd_color_q;
    assign cmd_x0    = x0_q;
    assign cmd_y0    = y0_q;
    assign cmd_x1    = x1_q;
    assign cmd_y1    = y1_q;
    assign err_op    = err_op_q;
`ifdef GPU_CMD_DEC_STATS_EN
    assign issued_cnt  = issued_q;
    assign dropped_cnt = dropped_q;
`endif

endmodule
